comp_counter: RTL and testbench
===============================

# comp_counter

Compare-and-count monitor for the 16-bit auto priority-queue datapath. Each enabled cycle it compares the incoming byte against the previously accepted byte and registers a "strictly greater" verdict. It also advances a wrap-around 4-bit occurrence counter whose terminal value 15 is flagged on `cteal_15`. It gives the queue control logic a registered rising-input indicator and a periodic 16-sample strobe.

## Interface
- `DATA_W`, default 8: width of `din` and of the stored comparison value.
- `CNT_W`, default 4: counter width. Terminal count is 2^CNT_W − 1, which is 15 at the default.
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low. Asserting it clears all state immediately, independent of `clk`.
- `enb`  input  1  sample enable. When low, all state holds and `din` is ignored (it may be X).
- `din`  input  DATA_W  data sample, unsigned.
- `verdict`  output  1  registered result: the last accepted sample was strictly greater than the sample accepted before it.
- `cteal_15`  output  1  high while the counter equals its terminal value (15).

## Operation
- State: `prev_q[DATA_W-1:0]`, `prev_vld_q`, `verdict_q`, `cnt_q[CNT_W-1:0]`.
- Reset (`rst`=0): all four state elements clear to 0. Outputs during and after reset: `verdict`=0, `cteal_15`=0.
- Rising edge with `enb`=1:
  - `verdict_q` ← `prev_vld_q` && (`din` > `prev_q`), unsigned compare.
  - `prev_q` ← `din`.
  - `prev_vld_q` ← 1.
  - `cnt_q` ← `cnt_q` + 1, modulo 2^CNT_W, so 15 wraps to 0.
- Rising edge with `enb`=0: nothing changes. Outputs hold their values indefinitely.
- First sample after reset: there is no valid previous sample, so `verdict` is 0 regardless of `din`.
- Equal values compare as not greater, so `verdict`=0. This includes 0 followed by 0 and 255 followed by 255.
- `verdict` = `verdict_q`.
- `cteal_15` = (`cnt_q` == all-ones). It is decoded from the register, not from inputs (Moore).
- No saturation. `cteal_15` is high for exactly one enabled cycle per 16 enabled cycles, and stays high while `enb` is held low at count 15.

## Timing
- Latency is one cycle. Sample k, accepted at edge k, drives `verdict` after edge k.
- `cteal_15` goes high after the 15th enabled edge following reset, then low after the 16th.
- Reset asserted mid-run clears the counter and the valid flag at once. The next accepted sample is treated as the first.
- Reset deassertion is asynchronous to `clk`. The integrator synchronizes it, so the block adds no extra synchronizer.
- No combinational path from `din`/`enb` to any output.

## Structure
- Shared package `compcount_pkg`: `DATA_W`, `CNT_W` defaults, and the typedefs `data_t` (`logic [DATA_W-1:0]`) and `cnt_t`.
- One sub-module: `wrap_counter` (parameter `CNT_W`; ports `clk`, `rst`, `enb`, `count`, `at_max`). It holds `cnt_q` and the terminal decode.
- The top level holds the comparator, `prev_q`/`prev_vld_q`, and the verdict register.
- Include SVA in the top:
  - `cteal_15` implies `cnt_q`==15.
  - `verdict` is 0 on the first enabled cycle after reset.
  - Outputs are stable whenever `enb`=0.

## Test plan
- **Reset:** hold `rst`=0 for 10 clocks, with `enb`=0 and `din`=X → `verdict`=0 and `cteal_15`=0 throughout.
- **Rising sequence:** release reset, `enb`=1, `din`=1 for 1 edge, then 5 for 10 edges. Required response:
  - `verdict` is 0 after edge 1.
  - `verdict` is 1 after edge 2, then 0 after edges 3–11 (equal values).
  - `cnt_q` is 11.
- **Mixed values:** continue with `din`=8 for 1 edge, 2 for 1 edge, then 254 for 10 edges. Required response:
  - `verdict` is 1 at edge 12, 0 at edge 13, 1 at edge 14, then 0.
  - `cteal_15` is 1 only after edge 15, and low again after edge 16 (count wraps to 0).
- **Enable gating:** drop `enb` at count 15 with `din`=255 for 5 clocks → `cteal_15` stays 1 and `verdict` is unchanged. Re-enable with `din`=255 → `cteal_15` falls and `verdict`=0.
- **Async reset mid-run:** assert `rst` between clock edges at count 9 → outputs clear before the next edge. The first sample after release gives `verdict`=0.
- **Extremes:** `din`=0 then 255 → `verdict`=1; then 255 then 0 → `verdict`=0.

Source files
------------

// File: rtl/compcount_pkg.sv
// Shared widths and types for the compare-and-count monitor.
// The top level and the counter take their parameter defaults from here.
package compcount_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/wrap_counter.sv
// Enabled wrap-around occurrence counter.
// Also provides a registered-state decode of the all-ones terminal value.
module wrap_counter #(
  parameter int CNT_W = compcount_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: assign the hold value before any condition so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (enb) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count  = cnt_q;
  assign at_max = &cnt_q;

endmodule

// File: rtl/comp_counter.sv
// Compare-and-count monitor: registers "sample strictly greater than previous"
// and flags the terminal value of a wrap-around occurrence counter.
module comp_counter #(
  parameter int DATA_W = compcount_pkg::DATA_W,
  parameter int CNT_W  = compcount_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [DATA_W-1:0] din,
  output logic              verdict,
  output logic              cteal_15
);

  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] prev_d;
  logic              prev_vld_q;
  logic              prev_vld_d;
  logic              verdict_q;
  logic              verdict_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              at_max;

  // The first sample after reset has nothing to compare against.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    verdict_d  = verdict_q;
    if (enb) begin
      verdict_d  = prev_vld_q && (din > prev_q);
      prev_d     = din;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      verdict_q  <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      verdict_q  <= verdict_d;
    end
  end

  wrap_counter #(
    .CNT_W (CNT_W)
  ) u_wrap_counter (
    .clk    (clk),
    .rst    (rst),
    .enb    (enb),
    .count  (cnt_q),
    .at_max (at_max)
  );

  assign verdict  = verdict_q;
  assign cteal_15 = at_max;

  a_terminal: assert property (@(posedge clk) disable iff (!rst)
    cteal_15 |-> (cnt_q == {CNT_W{1'b1}}));

  a_first_sample: assert property (@(posedge clk) disable iff (!rst)
    (enb && !prev_vld_q) |=> !verdict);

  a_hold: assert property (@(posedge clk) disable iff (!rst)
    !enb |=> ($stable(verdict) && $stable(cteal_15)));

endmodule

// File: tb/tb_comp_counter.sv
// Directed self-checking bench for comp_counter with hand-computed expectations.
module tb_comp_counter;
  import compcount_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  enb;
  data_t din;
  logic  verdict;
  logic  cteal_15;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comp_counter dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .din      (din),
    .verdict  (verdict),
    .cteal_15 (cteal_15)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one edge's inputs just after the previous edge, then sample 1 ns after the edge.
  task automatic step(input string tag, input logic e, input logic [7:0] d,
                      input logic exp_v, input logic exp_t);
    enb = e;
    din = d;
    @(posedge clk);
    #1;
    check({tag, ".verdict"}, verdict, exp_v);
    check({tag, ".cteal"}, cteal_15, exp_t);
  endtask

  initial begin
    rst = 1'b0;
    enb = 1'b0;
    din = 'x;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst.verdict", verdict, 1'b0);
      check("rst.cteal", cteal_15, 1'b0);
    end
    check("rst.cnt", dut.cnt_q, 0);
    rst = 1'b1;

    // Rising sequence: 1 then ten 5s.
    step("e1", 1'b1, 8'd1, 1'b0, 1'b0);
    step("e2", 1'b1, 8'd5, 1'b1, 1'b0);
    for (int i = 3; i <= 11; i++) step("eq5", 1'b1, 8'd5, 1'b0, 1'b0);
    check("cnt11", dut.cnt_q, 11);

    // Mixed values, with the terminal count at edge 15 and the wrap at edge 16.
    step("e12", 1'b1, 8'd8,   1'b1, 1'b0);
    step("e13", 1'b1, 8'd2,   1'b0, 1'b0);
    step("e14", 1'b1, 8'd254, 1'b1, 1'b0);
    step("e15", 1'b1, 8'd254, 1'b0, 1'b1);
    step("e16", 1'b1, 8'd254, 1'b0, 1'b0);
    check("cnt_wrap", dut.cnt_q, 0);
    for (int i = 17; i <= 23; i++) step("e254", 1'b1, 8'd254, 1'b0, 1'b0);

    // Walk to count 15 ending on a rising sample so the held verdict is 1.
    for (int i = 24; i <= 30; i++) step("e200", 1'b1, 8'd200, 1'b0, 1'b0);
    step("e31", 1'b1, 8'd255, 1'b1, 1'b1);
    check("cnt15", dut.cnt_q, 15);

    // Enable gating at the terminal count.
    for (int i = 0; i < 5; i++) step("gate", 1'b0, 8'd255, 1'b1, 1'b1);
    step("reen", 1'b1, 8'd255, 1'b0, 1'b0);

    // Run to count 9 with verdict high, then reset between edges.
    for (int i = 33; i <= 40; i++) step("e10", 1'b1, 8'd10, 1'b0, 1'b0);
    step("e41", 1'b1, 8'd20, 1'b1, 1'b0);
    check("cnt9", dut.cnt_q, 9);
    #2;
    rst = 1'b0;
    #1;
    check("async.verdict", verdict, 1'b0);
    check("async.cteal", cteal_15, 1'b0);
    check("async.cnt", dut.cnt_q, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Extremes; the first sample after reset never reports greater.
    step("x_first0", 1'b1, 8'd0,   1'b0, 1'b0);
    step("x_eq0",    1'b1, 8'd0,   1'b0, 1'b0);
    step("x_up255",  1'b1, 8'd255, 1'b1, 1'b0);
    step("x_eq255",  1'b1, 8'd255, 1'b0, 1'b0);
    step("x_dn0",    1'b1, 8'd0,   1'b0, 1'b0);
    check("cnt5", dut.cnt_q, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
